// File: rtl/bcd_pkg.sv
// Shared types and helpers for the serial BCD subtractor.
// Holds the FSM state enum, BCD digit limits and a digit validity check.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    FIX,
    DONE
  } state_t;

  localparam logic [3:0] BCD_TEN = 4'd10;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One-digit BCD subtractor: d = x - y - bin with decimal borrow.
// Ports: x, y (BCD digits), bin (borrow in) -> d (BCD digit), bout.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  logic [4:0] t;

  // t is a 5-bit two's-complement value; bit 4 set means negative.
  always_comb begin
    t    = {1'b0, x} - {1'b0, y} - {4'd0, bin};
    bout = t[4];
    d    = t[3:0];
    if (t[4]) d = t[3:0] + BCD_TEN;
  end

endmodule

// File: rtl/bcd_digit_serial_sub.sv
// Digit-serial packed-BCD subtractor, diff = a - b, LS digit first.
// Ports: clk, rst, start/ready handshake, a, b in; done, diff,
// borrow, neg, err out. Macro SIGN_MAG_EN adds a FIX pass
// that turns negative results into sign-magnitude form.
module bcd_digit_serial_sub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                ready,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                borrow,
  output logic                neg,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t state;
  state_t state_nx;

  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  r_sh;
  logic [W-1:0]  r_nx;
  logic [IW-1:0] idx;
  logic          brw;
  logic          err_l;
  logic          bad;
  logic          accept;
  logic          last;
  logic          busy;
  logic          fix_go;
  logic [3:0]    x;
  logic [3:0]    y;
  logic [3:0]    d;
  logic          bout;

  assign ready  = (state == IDLE) || (state == DONE);
  assign done   = (state == DONE);
  assign accept = start && ready;
  assign last   = (idx == LAST);
  assign busy   = (state == SUB) || (state == FIX);

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(a[4*i +: 4]) || !is_bcd(b[4*i +: 4])) bad = 1'b1;
    end
  end

  // FIX reuses the digit slice as 0 - r_i - brw on the raw result.
  always_comb begin
    x = a_sh[3:0];
    y = b_sh[3:0];
    if (state == FIX) begin
      x = 4'd0;
      y = r_sh[3:0];
    end
  end

  bcd_digit_sub u_dsub (
    .x    (x),
    .y    (y),
    .bin  (brw),
    .d    (d),
    .bout (bout)
  );

  // New digit enters at the top; after DIGITS steps it is in order.
  assign r_nx = (r_sh >> 4) | (W'(d) << (W - 4));

`ifdef SIGN_MAG_EN
  assign fix_go = bout && !err_l;
`else
  assign fix_go = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = SUB;
      SUB:  if (last) state_nx = fix_go ? FIX : DONE;
      FIX:  if (last) state_nx = DONE;
      DONE: state_nx = start ? SUB : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      idx    <= '0;
      brw    <= 1'b0;
      err_l  <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      err    <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      r_sh  <= '0;
      idx   <= '0;
      brw   <= 1'b0;
      err_l <= bad;
    end else if (busy) begin
      a_sh <= a_sh >> 4;
      b_sh <= b_sh >> 4;
      r_sh <= r_nx;
      brw  <= bout;
      idx  <= idx + 1'b1;
      if (last) begin
        idx <= '0;
        if (state_nx == FIX) begin
          brw <= 1'b0;
        end else begin
          diff   <= err_l ? '0 : r_nx;
          borrow <= !err_l && ((state == FIX) || bout);
          err    <= err_l;
        end
      end
    end
  end

`ifdef SIGN_MAG_EN
  logic neg_q;

  always_ff @(posedge clk) begin
    if (rst) neg_q <= 1'b0;
    else if (busy && last && state_nx == DONE)
      neg_q <= (state == FIX);
  end

  assign neg = neg_q;
`else
  assign neg = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_digit_serial_sub.sv
// Self-checking bench for bcd_digit_serial_sub (DIGITS=4).
// Directed cases, handshake/reset checks and random operands.
module tb_bcd_digit_serial_sub;

  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [4*D-1:0] a;
  logic [4*D-1:0] b;
  logic          ready;
  logic          done;
  logic [4*D-1:0] diff;
  logic          borrow;
  logic          neg;
  logic          err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_digit_serial_sub #(.DIGITS(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .neg    (neg),
    .err    (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [4*D-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [4*D-1:0] int2bcd(input int v);
    logic [4*D-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [4*D-1:0] v);
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Decimal reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [4*D-1:0] ma, input logic [4*D-1:0] mb,
                       output logic [4*D-1:0] e_diff, output logic e_brw,
                       output logic e_neg, output logic e_err,
                       output int e_lat);
    int av, bv, md;
    md = 1;
    for (int i = 0; i < D; i++) md = md * 10;
    e_err = has_bad(ma) || has_bad(mb);
    e_lat = D + 1;
    e_diff = '0;
    e_brw = 1'b0;
    e_neg = 1'b0;
    if (!e_err) begin
      av = bcd2int(ma);
      bv = bcd2int(mb);
      e_brw = av < bv;
`ifdef SIGN_MAG_EN
      e_neg  = e_brw;
      e_diff = int2bcd(e_brw ? bv - av : av - bv);
      if (e_brw) e_lat = 2 * D + 1;
`else
      e_diff = int2bcd((av - bv + md) % md);
`endif
    end
  endtask

  task automatic run_op(input string tag, input logic [4*D-1:0] ta,
                        input logic [4*D-1:0] tb);
    logic [4*D-1:0] e_diff;
    logic e_brw, e_neg, e_err;
    int e_lat;
    int k;
    model(ta, tb, e_diff, e_brw, e_neg, e_err, e_lat);
    a = ta;
    b = tb;
    start = 1'b1;
    @(posedge clk);
    k = 0;
    for (int c = 1; c <= 4 * D + 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) chk({tag, ".busy_ready"}, ready, 0);
      if (done) begin
        k = c;
        break;
      end
    end
    if (k == 0) begin
      chk({tag, ".timeout"}, 0, 1);
    end else begin
      chk({tag, ".lat"}, k, e_lat);
      chk({tag, ".diff"}, diff, e_diff);
      chk({tag, ".borrow"}, borrow, e_brw);
      chk({tag, ".neg"}, neg, e_neg);
      chk({tag, ".err"}, err, e_err);
      chk({tag, ".ready"}, ready, 1);
      @(negedge clk);
      chk({tag, ".hold"}, {done, diff}, {1'b0, e_diff});
    end
  endtask

  initial begin
    logic [4*D-1:0] ra, rb;
    int ndone, first;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst.ready", ready, 1);
    chk("rst.outs", {done, diff, borrow, neg, err}, 0);

    run_op("d0042", 16'h0042, 16'h0017);
    run_op("d0100", 16'h0100, 16'h0001);
    run_op("d0017", 16'h0017, 16'h0042);
    run_op("d9999", 16'h9999, 16'h9999);
    run_op("d00A1", 16'h00A1, 16'h0001);
    run_op("dwrap", 16'h0000, 16'h0001);

    // Starts during a busy operation must be ignored.
    a = 16'h0042;
    b = 16'h0017;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'h9999;
    b = 16'h0000;
    ndone = 0;
    first = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 4) start = 1'b0;
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = c;
          chk("ign.diff", diff, 16'h0025);
        end
      end
      @(negedge clk);
    end
    chk("ign.count", ndone, 1);
    chk("ign.lat", first, D + 1);

    // Reset asserted in cycle 2 of an operation.
    run_op("pre_rst", 16'h0017, 16'h0042);
    a = 16'h0500;
    b = 16'h0123;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst.ready", ready, 1);
    chk("mid_rst.outs", {done, diff, borrow, neg, err}, 0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("mid_rst.nodone", ndone, 0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < D; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0)
        ra[4*$urandom_range(0, D - 1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0)
        rb[4*$urandom_range(0, D - 1) +: 4] = 4'($urandom_range(10, 15));
      run_op("rnd", ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
